// File: rtl/cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter
//
// Shares one downstream line port (pmem_*) between an instruction cache (i_*)
// and a data cache (d_*). One transaction runs at a time:
//   IDLE     -> grant a pending requester and latch its address, op and data
//   BUSY_I/D -> hold exactly one pmem command until pmem_resp
//   RECOVER  -> one quiet cycle that ignores all requests, then back to IDLE
// When both caches are waiting in IDLE, the one that did not win the previous
// grant goes first. After reset the instruction cache wins the first tie.
//
// Ports
//   clk          : single clock, rising edge
//   rst          : asynchronous active-low reset (0 resets, 1 runs)
//   i_read       : I-cache line read request, held until i_resp
//   i_addr       : I-cache line address
//   i_rdata      : line returned to the I-cache (always pmem_rdata)
//   i_resp       : I-cache completion pulse
//   d_read       : D-cache line read request, held until d_resp
//   d_write      : D-cache writeback request, held until d_resp
//   d_addr       : D-cache line address
//   d_wdata      : D-cache writeback line
//   d_rdata      : line returned to the D-cache (always pmem_rdata)
//   d_resp       : D-cache completion pulse
//   pmem_read    : downstream read command
//   pmem_write   : downstream write command
//   pmem_addr    : downstream address (from the latched transaction)
//   pmem_wdata   : downstream write line (from the latched transaction)
//   pmem_rdata   : downstream return line
//   pmem_resp    : downstream completion pulse
// -----------------------------------------------------------------------------
module cache_mem_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // instruction cache
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  // data cache
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  // downstream line port
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY_I  = 2'd1,
    S_BUSY_D  = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  // 0 = instruction cache won the last grant, 1 = data cache
  logic                r_last_grant;

  // Latched transaction; the downstream port is driven only from these.
  logic [ADDR_W-1:0]   r_addr;
  logic                r_write;
  logic [LINE_W-1:0]   r_wdata;

  logic                w_i_pend;
  logic                w_d_pend;
  logic                w_grant_i;
  logic                w_grant_d;

  assign w_i_pend = i_read;
  assign w_d_pend = d_read | d_write;

  // ---------------------------------------------------------------------------
  // Next state, grant and command/response decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    i_resp      = 1'b0;
    d_resp      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_i_pend && w_d_pend) begin
          // Tie: serve whichever side did not get the previous grant.
          w_grant_i = r_last_grant;
          w_grant_d = ~r_last_grant;
        end else begin
          w_grant_i = w_i_pend;
          w_grant_d = w_d_pend;
        end
        if (w_grant_i) begin
          w_state_nxt = S_BUSY_I;
        end else if (w_grant_d) begin
          w_state_nxt = S_BUSY_D;
        end
      end

      S_BUSY_I: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          i_resp      = 1'b1;
          w_state_nxt = S_RECOVER;
        end
      end

      S_BUSY_D: begin
        pmem_read  = ~r_write;
        pmem_write = r_write;
        if (pmem_resp) begin
          d_resp      = 1'b1;
          w_state_nxt = S_RECOVER;
        end
      end

      S_RECOVER: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register and grant bookkeeping
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_i) begin
        r_last_grant <= 1'b0;
      end else if (w_grant_d) begin
        r_last_grant <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transaction latches, loaded only at grant so later request changes cannot
  // disturb the transaction in flight.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the wide data latch is reset as well, so pmem_wdata reads 0 out of
    // reset instead of whatever the flops powered up with.
    if (!rst) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
    end else if (w_grant_i) begin
      r_addr  <= i_addr;
      r_write <= 1'b0;
    end else if (w_grant_d) begin
      r_addr  <= d_addr;
      // read and write together is treated as a writeback
      r_write <= d_write;
      r_wdata <= d_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath outputs
  // ---------------------------------------------------------------------------
  assign pmem_addr  = r_addr;
  assign pmem_wdata = r_wdata;

  // Both caches see the return line at all times; only the resp pulses steer.
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule
